// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding instruction fetcher with a 2-entry buffer.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   PC                      current program counter from the upstream PC register
//   pc_advance              combinational pulse: PC controller selects PC+4 at next edge
//   flush                   redirect; discards buffered and in-flight fetches
//   mem_req/mem_addr        instruction-memory request and registered address
//   mem_ack/mem_rdata       memory response strobe and instruction word (same cycle)
//   inst_valid/inst_ready   head-of-buffer handshake towards decode
//   inst/inst_pc            head instruction word and its address
//   align_fault             high while parked on a misaligned PC
module instruction_fetch (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] PC,
  output logic        pc_advance,
  input  logic        flush,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  output logic        align_fault
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned CNT_W = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] word;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [XLEN-1:0] r_mem_addr;
  logic [CNT_W-1:0] r_count;
  logic            r_valid;
  entry_t          r_head;
  entry_t          r_tail;
  entry_t          w_new;
  logic            w_has_room;
  logic            w_start;
  logic            w_push;
  logic            w_pop;

  assign w_has_room = (r_count < CNT_W'(2));
  assign w_start    = (r_state == S_IDLE) && !flush && w_has_room && (PC[1:0] == 2'b00);
  assign w_pop      = r_valid && inst_ready;
  assign w_new      = '{pc: r_mem_addr, word: mem_rdata};

  // State register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; an ack always ends the outstanding transaction
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (!flush && w_has_room)
          w_next_state = (PC[1:0] == 2'b00) ? S_REQ : S_FAULT;
      end
      S_REQ: begin
        if (mem_ack)    w_next_state = S_IDLE;
        else if (flush) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (mem_ack) w_next_state = S_IDLE;
      end
      S_FAULT: begin
        if (flush) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode; pc_advance is the same-cycle push strobe
  always_comb begin
    mem_req     = 1'b0;
    align_fault = 1'b0;
    w_push      = 1'b0;
    case (r_state)
      S_REQ:   begin
        mem_req = 1'b1;
        w_push  = mem_ack && !flush && !reset;
      end
      S_DRAIN: mem_req = 1'b1;
      S_FAULT: align_fault = 1'b1;
      default: ;
    endcase
    pc_advance = w_push;
  end

  // Request address, captured when leaving IDLE towards REQ
  always_ff @(posedge clock) begin
    if (reset)        r_mem_addr <= '0;
    else if (w_start) r_mem_addr <= PC;
  end

  // Two-entry buffer: head register feeds decode, tail holds the second entry
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
      r_valid <= 1'b0;
      r_head  <= '0;
      r_tail  <= '0;
    end else if (flush) begin
      r_count <= '0;
      r_valid <= 1'b0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == CNT_W'(0)) r_head <= w_new;
          else                      r_tail <= w_new;
          r_count <= r_count + CNT_W'(1);
          r_valid <= 1'b1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - CNT_W'(1);
          r_valid <= (r_count == CNT_W'(2));
        end
        2'b11: begin
          // Count unchanged; the new entry lands behind whatever remains
          if (r_count == CNT_W'(2)) begin
            r_head <= r_tail;
            r_tail <= w_new;
          end else begin
            r_head <= w_new;
          end
        end
        default: ;
      endcase
    end
  end

  // A push into a full buffer would mean REQ was entered without room
  always_ff @(posedge clock) begin
    if (!reset && w_push) assert (r_count < CNT_W'(2));
  end

  assign mem_addr   = r_mem_addr;
  assign inst_valid = r_valid;
  assign inst       = r_head.word;
  assign inst_pc    = r_head.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized
// run scored against a transaction-level model (expected-instruction queue).
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] PC;
  logic        pc_advance;
  logic        flush;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        align_fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] word;
  } ent_t;

  instruction_fetch dut (
    .clock      (clock),
    .reset      (reset),
    .PC         (PC),
    .pc_advance (pc_advance),
    .flush      (flush),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .align_fault(align_fault)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h13579BDF;
  endfunction

  task automatic tick();
    @(negedge clock);
  endtask

  // Redirect to new_pc and end any transaction; leaves the DUT idle and empty
  task automatic cleanup(input logic [63:0] new_pc);
    flush = 1'b1; mem_ack = 1'b1; inst_ready = 1'b0; PC = new_pc;
    tick();
    flush = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0; inst_ready = 1'b0; PC = '0;
    tick(); tick();
    #1;
    checks++; if (mem_req !== 1'b0)     begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    checks++; if (pc_advance !== 1'b0)  begin errors++; $display("FAIL reset_pc_advance got %b want 0", pc_advance); end
    checks++; if (inst_valid !== 1'b0)  begin errors++; $display("FAIL reset_inst_valid got %b want 0", inst_valid); end
    checks++; if (align_fault !== 1'b0) begin errors++; $display("FAIL reset_align_fault got %b want 0", align_fault); end
    checks++; if (mem_addr !== 64'h0)   begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++; if (inst !== 32'h0)       begin errors++; $display("FAIL reset_inst got %h want 0", inst); end
    checks++; if (inst_pc !== 64'h0)    begin errors++; $display("FAIL reset_inst_pc got %h want 0", inst_pc); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_fetch();
    cleanup(64'h0);
    tick();
    #1;
    checks++; if (mem_req !== 1'b1)    begin errors++; $display("FAIL basic_req got %b want 1", mem_req); end
    checks++; if (mem_addr !== 64'h0)  begin errors++; $display("FAIL basic_addr got %h want 0", mem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", inst_valid); end
    mem_ack = 1'b1; mem_rdata = 32'h8B020020;
    #1;
    checks++; if (pc_advance !== 1'b1) begin errors++; $display("FAIL basic_advance got %b want 1", pc_advance); end
    PC = PC + 64'd4;
    tick();
    mem_ack = 1'b0;
    #1;
    checks++; if (pc_advance !== 1'b0)    begin errors++; $display("FAIL basic_advance_pulse got %b want 0", pc_advance); end
    checks++; if (inst_valid !== 1'b1)    begin errors++; $display("FAIL basic_valid got %b want 1", inst_valid); end
    checks++; if (inst !== 32'h8B020020)  begin errors++; $display("FAIL basic_inst got %h want 8b020020", inst); end
    checks++; if (inst_pc !== 64'h0)      begin errors++; $display("FAIL basic_inst_pc got %h want 0", inst_pc); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL basic_flush_valid got %b want 0", inst_valid); end
  endtask

  task automatic test_backpressure();
    int pushes = 0;
    bit saw8 = 1'b0;
    cleanup(64'h0);
    for (int i = 0; i < 10; i++) begin
      mem_ack = mem_req;
      mem_rdata = mem_word(mem_addr);
      #1;
      if (mem_req && mem_addr == 64'h8) saw8 = 1'b1;
      if (pc_advance) begin pushes++; PC = PC + 64'd4; end
      tick();
    end
    mem_ack = 1'b0;
    #1;
    checks++; if (pushes != 2)      begin errors++; $display("FAIL bp_pushes got %0d want 2", pushes); end
    checks++; if (saw8 !== 1'b0)    begin errors++; $display("FAIL bp_early_req8 got %b want 0", saw8); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_full got %b want 0", mem_req); end
    checks++; if (inst_pc !== 64'h0 || inst !== mem_word(64'h0))
      begin errors++; $display("FAIL bp_head0 got %h/%h want 0/%h", inst_pc, inst, mem_word(64'h0)); end
    inst_ready = 1'b1;
    tick();
    #1;
    checks++; if (inst_pc !== 64'h4 || inst !== mem_word(64'h4))
      begin errors++; $display("FAIL bp_head1 got %h/%h want 4/%h", inst_pc, inst, mem_word(64'h4)); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_after_pop got %b want 0", mem_req); end
    inst_ready = 1'b0;
    tick();
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h8)
      begin errors++; $display("FAIL bp_req8 got %b/%h want 1/8", mem_req, mem_addr); end
  endtask

  task automatic test_flush_wait();
    cleanup(64'h100);
    tick();
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h100)
      begin errors++; $display("FAIL fw_req got %b/%h want 1/100", mem_req, mem_addr); end
    flush = 1'b1; PC = 64'h200;
    #1;
    checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL fw_adv_flush got %b want 0", pc_advance); end
    tick();
    flush = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h100)
      begin errors++; $display("FAIL fw_drain got %b/%h want 1/100", mem_req, mem_addr); end
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL fw_adv_drain got %b want 0", pc_advance); end
    tick();
    mem_ack = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0 || mem_req !== 1'b0)
      begin errors++; $display("FAIL fw_discard got valid %b req %b want 0/0", inst_valid, mem_req); end
    tick();
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h200)
      begin errors++; $display("FAIL fw_newpc got %b/%h want 1/200", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = mem_word(64'h200);
    #1;
    PC = PC + 64'd4;
    tick();
    mem_ack = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h200 || inst !== mem_word(64'h200))
      begin errors++; $display("FAIL fw_fetch got %b/%h/%h want 1/200/%h", inst_valid, inst_pc, inst, mem_word(64'h200)); end
  endtask

  task automatic test_flush_ack();
    cleanup(64'h40);
    tick();
    mem_ack = 1'b1; mem_rdata = mem_word(64'h40);
    #1;
    PC = PC + 64'd4;
    tick();
    mem_ack = 1'b0;
    tick();
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h44 || inst_valid !== 1'b1)
      begin errors++; $display("FAIL fa_setup got %b/%h/%b want 1/44/1", mem_req, mem_addr, inst_valid); end
    flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0; PC = 64'h80;
    #1;
    checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL fa_adv got %b want 0", pc_advance); end
    tick();
    flush = 1'b0; mem_ack = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0 || mem_req !== 1'b0)
      begin errors++; $display("FAIL fa_drop got valid %b req %b want 0/0", inst_valid, mem_req); end
    tick();
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h80)
      begin errors++; $display("FAIL fa_newpc got %b/%h want 1/80", mem_req, mem_addr); end
  endtask

  task automatic test_misaligned();
    cleanup(64'h30);
    tick();
    mem_ack = 1'b1; mem_rdata = mem_word(64'h30);
    #1;
    tick();
    mem_ack = 1'b0; PC = 64'h6;
    tick();
    #1;
    checks++; if (align_fault !== 1'b1 || mem_req !== 1'b0)
      begin errors++; $display("FAIL mis_fault got %b req %b want 1/0", align_fault, mem_req); end
    checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h30)
      begin errors++; $display("FAIL mis_buffered got %b/%h want 1/30", inst_valid, inst_pc); end
    inst_ready = 1'b1; mem_ack = 1'b1;
    #1;
    checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL mis_adv got %b want 0", pc_advance); end
    tick();
    inst_ready = 1'b0; mem_ack = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0 || align_fault !== 1'b1 || mem_req !== 1'b0)
      begin errors++; $display("FAIL mis_pop got %b/%b/%b want 0/1/0", inst_valid, align_fault, mem_req); end
    flush = 1'b1; PC = 64'h10;
    tick();
    flush = 1'b0;
    #1;
    checks++; if (align_fault !== 1'b0) begin errors++; $display("FAIL mis_clear got %b want 0", align_fault); end
    tick();
    #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h10 || align_fault !== 1'b0)
      begin errors++; $display("FAIL mis_refetch got %b/%h/%b want 1/10/0", mem_req, mem_addr, align_fault); end
  endtask

  task automatic test_reset_mid();
    cleanup(64'h20);
    tick();
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_req got %b want 1", mem_req); end
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = mem_word(64'h20);
    #1;
    checks++; if (mem_req !== 1'b0 || pc_advance !== 1'b0 || inst_valid !== 1'b0 || align_fault !== 1'b0)
      begin errors++; $display("FAIL rm_ctrl got %b%b%b%b want 0000", mem_req, pc_advance, inst_valid, align_fault); end
    checks++; if (mem_addr !== 64'h0 || inst !== 32'h0 || inst_pc !== 64'h0)
      begin errors++; $display("FAIL rm_data got %h/%h/%h want 0/0/0", mem_addr, inst, inst_pc); end
    tick();
    mem_ack = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rm_nopush got %b want 0", inst_valid); end
    checks++; if (mem_req !== 1'b1 || mem_addr !== 64'h20)
      begin errors++; $display("FAIL rm_refetch got %b/%h want 1/20", mem_req, mem_addr); end
  endtask

  task automatic test_random();
    ent_t q[$];
    ent_t e;
    bit stale = 1'b0;
    bit exp_adv;
    int wait_cnt = 0;
    int pops = 0;
    logic [63:0] npc;
    cleanup(64'h1000);
    for (int cyc = 0; cyc < 600; cyc++) begin
      flush = ($urandom_range(31) == 0);
      if (flush) begin
        npc = {$urandom(), $urandom()};
        npc[1:0] = 2'b00;
        PC = npc;
      end
      inst_ready = ($urandom_range(1) == 1);
      if (mem_req) begin
        if (wait_cnt == 0) begin mem_ack = 1'b1; wait_cnt = $urandom_range(2); end
        else begin mem_ack = 1'b0; wait_cnt--; end
      end else begin
        mem_ack = ($urandom_range(3) == 0);
      end
      mem_rdata = mem_ack ? mem_word(mem_addr) : $urandom();
      #1;
      exp_adv = mem_req && mem_ack && !flush && !stale;
      checks++; if (pc_advance !== exp_adv)
        begin errors++; $display("FAIL rnd_adv cyc %0d got %b want %b", cyc, pc_advance, exp_adv); end
      checks++; if (inst_valid !== (q.size() != 0))
        begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", cyc, inst_valid, q.size() != 0); end
      if (mem_req && !stale && !flush) begin
        checks++; if (mem_addr !== PC)
          begin errors++; $display("FAIL rnd_addr cyc %0d got %h want %h", cyc, mem_addr, PC); end
      end
      if (inst_valid && inst_ready && !flush && q.size() != 0) begin
        e = q.pop_front();
        pops++;
        checks++; if (inst_pc !== e.pc || inst !== e.word)
          begin errors++; $display("FAIL rnd_head cyc %0d got %h/%h want %h/%h", cyc, inst_pc, inst, e.pc, e.word); end
      end
      if (exp_adv) begin
        e.pc = PC; e.word = mem_word(PC);
        q.push_back(e);
        PC = PC + 64'd4;
      end
      if (flush) q.delete();
      if (mem_req && mem_ack) stale = 1'b0;
      else if (flush && mem_req) stale = 1'b1;
      checks++; if (q.size() > 2)
        begin errors++; $display("FAIL rnd_overfill cyc %0d got %0d entries want <=2", cyc, q.size()); end
      tick();
    end
    flush = 1'b0; mem_ack = 1'b0;
    checks++; if (pops < 20) begin errors++; $display("FAIL rnd_progress got %0d pops want >=20", pops); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_flush_wait();
    test_flush_ack();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
